// File: rtl/id_ex_pipeline_reg_pkg.sv
// ============================================================================
// Package     : riscv_defs
// Description : Shared widths, ALU op / writeback encodings and the ID/EX
//               register payload type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_defs;

  localparam int XLEN    = 32;
  localparam int ALUOP_W = 4;
  localparam int REG_AW  = 5;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [XLEN-1:0]     imm;
    logic [REG_AW-1:0]   rd;
    logic [ALUOP_W-1:0]  alu_op;
    logic                alu_src;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic [1:0]          wb_sel;
  } id_ex_t;

endpackage

`default_nettype wire

// File: rtl/id_ex_pipeline_reg_load_use_detect.sv
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard detect between EX and ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
  import riscv_defs::*;
(
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              load_use
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

`default_nettype wire

// File: rtl/id_ex_pipeline_reg.sv
// ============================================================================
// Module      : id_ex_pipeline_reg
// Description : ID/EX pipeline register with load-use bubble insertion,
//               stall hold and flush. Optional bubble counter when the
//               macro ID_EX_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_pipeline_reg
  import riscv_defs::*;
(
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_alu_src,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_reg_write,
  input  logic [1:0]         id_wb_sel,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [REG_AW-1:0]  ex_rs1,
  output logic [REG_AW-1:0]  ex_rs2,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [XLEN-1:0]    ex_imm,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_reg_write,
  output logic [1:0]         ex_wb_sel,
`ifdef ID_EX_PERF_EN
  output logic [31:0]        bubble_cnt,
`endif
  output logic               hazard_stall
);

  id_ex_t r_ex;
  id_ex_t w_capture;
  logic   w_load_use;
  logic   w_bubble;

`ifdef ID_EX_PERF_EN
  logic [31:0] r_bubble_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

  load_use_detect u_load_use_detect (
    .ex_valid    (r_ex.valid),
    .ex_mem_read (r_ex.mem_read),
    .ex_rd       (r_ex.rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .load_use    (w_load_use)
  );

  always_comb begin
    w_capture           = '0;
    w_capture.valid     = id_valid;
    w_capture.pc        = id_pc;
    w_capture.rs1       = id_rs1;
    w_capture.rs2       = id_rs2;
    w_capture.rs1_data  = id_rs1_data;
    w_capture.rs2_data  = id_rs2_data;
    w_capture.imm       = id_imm;
    w_capture.rd        = id_rd;
    // An empty ID slot must never carry live controls into EX
    if (id_valid) begin
      w_capture.alu_op    = id_alu_op;
      w_capture.alu_src   = id_alu_src;
      w_capture.mem_read  = id_mem_read;
      w_capture.mem_write = id_mem_write;
      w_capture.reg_write = id_reg_write;
      w_capture.wb_sel    = id_wb_sel;
    end
  end

  // Flush outranks stall; a load-use bubble is only written when not stalled
  assign w_bubble     = flush_i | w_load_use;
  assign hazard_stall = w_load_use & ~flush_i & ~stall_i;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ex <= '0;
`ifdef ID_EX_PERF_EN
      r_bubble_cnt <= 32'd0;
`endif
    end else if (flush_i || !stall_i) begin
      r_ex <= w_bubble ? '0 : w_capture;
`ifdef ID_EX_PERF_EN
      if (w_bubble) r_bubble_cnt <= r_bubble_cnt + 32'd1;
`endif
    end
  end

  assign ex_valid     = r_ex.valid;
  assign ex_pc        = r_ex.pc;
  assign ex_rs1       = r_ex.rs1;
  assign ex_rs2       = r_ex.rs2;
  assign ex_rs1_data  = r_ex.rs1_data;
  assign ex_rs2_data  = r_ex.rs2_data;
  assign ex_imm       = r_ex.imm;
  assign ex_rd        = r_ex.rd;
  assign ex_alu_op    = r_ex.alu_op;
  assign ex_alu_src   = r_ex.alu_src;
  assign ex_mem_read  = r_ex.mem_read;
  assign ex_mem_write = r_ex.mem_write;
  assign ex_reg_write = r_ex.reg_write;
  assign ex_wb_sel    = r_ex.wb_sel;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipeline_reg.sv
// ============================================================================
// Module      : tb_id_ex_pipeline_reg
// Description : Directed self-checking bench for id_ex_pipeline_reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_pipeline_reg;
  import riscv_defs::*;

  logic               CLK = 1'b0;
  logic               RESET_N;
  logic               stall_i, flush_i, id_valid;
  logic [XLEN-1:0]    id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REG_AW-1:0]  id_rs1, id_rs2, id_rd;
  logic [ALUOP_W-1:0] id_alu_op;
  logic               id_alu_src, id_mem_read, id_mem_write, id_reg_write;
  logic [1:0]         id_wb_sel;
  logic               ex_valid;
  logic [XLEN-1:0]    ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REG_AW-1:0]  ex_rs1, ex_rs2, ex_rd;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic               ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [1:0]         ex_wb_sel;
  logic               hazard_stall;
`ifdef ID_EX_PERF_EN
  logic [31:0]        bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  id_ex_pipeline_reg dut (
    .CLK(CLK), .RESET_N(RESET_N), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rd(id_rd), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_wb_sel(id_wb_sel),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_wb_sel(ex_wb_sel),
`ifdef ID_EX_PERF_EN
    .bubble_cnt(bubble_cnt),
`endif
    .hazard_stall(hazard_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic rw, input logic src,
                       input logic [31:0] imm);
    id_valid     = v;
    id_pc        = pc;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_mem_read  = mr;
    id_reg_write = rw;
    id_alu_src   = src;
    id_imm       = imm;
    id_rs1_data  = pc ^ 32'hA5A5_0000;
    id_rs2_data  = pc ^ 32'h0000_5A5A;
    id_alu_op    = mr ? ALU_ADD : ALU_OR;
    id_wb_sel    = mr ? WB_SEL_MEM : WB_SEL_ALU;
    id_mem_write = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_hazard", {31'd0, hazard_stall}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Pass-through of an immediate-form ALU instruction
    drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 32'h14);
    tick();
    check("pt_pc", ex_pc, 32'h100);
    check("pt_imm", ex_imm, 32'h14);
    check("pt_alu_src", {31'd0, ex_alu_src}, 32'd1);
    check("pt_valid", {31'd0, ex_valid}, 32'd1);
    check("pt_rd", {27'd0, ex_rd}, 32'd5);
    check("pt_rs1_data", ex_rs1_data, 32'hA5A5_0100);
    check("pt_alu_op", {28'd0, ex_alu_op}, {28'd0, ALU_OR});

    // Asynchronous reset between edges
    #2 RESET_N = 1'b0;
    #1;
    check("async_valid", {31'd0, ex_valid}, 32'd0);
    check("async_pc", ex_pc, 32'd0);
    check("async_reg_write", {31'd0, ex_reg_write}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Load-use on rs1
    drive(1'b1, 32'h200, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'h8);
    tick();
    check("lu_ld_mem_read", {31'd0, ex_mem_read}, 32'd1);
    drive(1'b1, 32'h204, 5'd3, 5'd4, 5'd6, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    check("lu_hazard", {31'd0, hazard_stall}, 32'd1);
    tick();
    check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("lu_bubble_mem_read", {31'd0, ex_mem_read}, 32'd0);
    check("lu_hazard_clear", {31'd0, hazard_stall}, 32'd0);
    tick();
    check("lu_cap_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_cap_rs1", {27'd0, ex_rs1}, 32'd3);
    check("lu_cap_pc", ex_pc, 32'h204);

    // Load to x0 creates no hazard
    drive(1'b1, 32'h300, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h304, 5'd0, 5'd9, 5'd7, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    check("x0_hazard", {31'd0, hazard_stall}, 32'd0);
    tick();
    check("x0_valid", {31'd0, ex_valid}, 32'd1);
    check("x0_pc", ex_pc, 32'h304);

    // Stall held for three edges with load-use pending on rs2
    drive(1'b1, 32'h400, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h404, 5'd8, 5'd7, 5'd10, 1'b0, 1'b1, 1'b0, 32'h0);
    stall_i = 1'b1;
    #1;
    check("st_hazard_pre", {31'd0, hazard_stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_pc", ex_pc, 32'h400);
      check("st_valid", {31'd0, ex_valid}, 32'd1);
      check("st_mem_read", {31'd0, ex_mem_read}, 32'd1);
      check("st_hazard", {31'd0, hazard_stall}, 32'd0);
    end
    stall_i = 1'b0;
    #1;
    check("st_hazard_rel", {31'd0, hazard_stall}, 32'd1);
    tick();
    check("st_bubble", {31'd0, ex_valid}, 32'd0);
    tick();
    check("st_cap_pc", ex_pc, 32'h404);
    check("st_cap_rs2", {27'd0, ex_rs2}, 32'd7);

    // Flush together with stall writes a bubble
    flush_i = 1'b1;
    stall_i = 1'b1;
    tick();
    check("fs_valid", {31'd0, ex_valid}, 32'd0);
    check("fs_reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("fs_pc", ex_pc, 32'd0);
`ifdef ID_EX_PERF_EN
    check("fs_bubble_cnt", bubble_cnt, 32'd3);
`endif

    // Invalid ID slot forces controls to zero
    flush_i = 1'b0;
    stall_i = 1'b0;
    drive(1'b0, 32'h500, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1, 1'b1, 32'h4);
    tick();
    check("iv_valid", {31'd0, ex_valid}, 32'd0);
    check("iv_reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("iv_mem_read", {31'd0, ex_mem_read}, 32'd0);
    check("iv_pc", ex_pc, 32'h500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
